regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the fixed 32x32 register file used by the decode stage.
- Scales register width, register count and read-port count.
- Adds a per-register pending-write scoreboard: decode stalls on RAW hazards and a full scoreboard without separate hazard logic in decode.
- Sits between decode (read/issue) and writeback (write/retire).

Parameters:
- XLEN, 32, register data width in bits.
- REG_COUNT, 32, number of architectural registers; power of two, at least 2; AW = $clog2(REG_COUNT).
- NUM_READ, 2, number of independent read ports.
- CNT_W, 2, width of each per-register pending-write counter; maximum pending writes per register = 2^CNT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr_i  in  NUM_READ*AW  read addresses, port k at bits [k*AW +: AW].
- rd_data_o  out  NUM_READ*XLEN  read data, combinational from rd_addr_i.
- rd_busy_o  out  NUM_READ  port k source has pending writes (RAW hazard).
- issue_valid_i  in  1  decode issues an instruction that will write issue_rd_i.
- issue_rd_i  in  AW  destination of the issued instruction.
- issue_ready_o  out  1  issue accepted this cycle.
- wb_valid_i  in  1  writeback valid.
- wb_rd_i  in  AW  writeback destination.
- wb_data_i  in  XLEN  writeback data.
- flush_i  in  1  pipeline flush; clears the scoreboard.
- hazard_o  out  1  OR of rd_busy_o over all ports.

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, all counters 0.
- Reset outputs: rd_data_o = 0, rd_busy_o = 0, hazard_o = 0, issue_ready_o = 1.
- Register 0: reads always 0, writes ignored, counter always 0, never busy. Issue to rd=0 is accepted with no counter change.
- Write: on a clock edge with wb_valid_i and wb_rd_i != 0, regs[wb_rd_i] <= wb_data_i. Write latency is 1 cycle.
- Read: rd_data_o[k] = regs[rd_addr_i[k]], combinational.
  - Same-cycle write to the same address is governed by REGFILE_BYPASS_EN.
- rd_busy_o[k]: high when cnt[rd_addr_i[k]] != 0 after the same-cycle writeback adjustment (see the optional feature).
- Counter update per register r, per edge:
  - inc = issue_valid_i & issue_ready_o & issue_rd_i == r & r != 0.
  - dec = wb_valid_i & wb_rd_i == r & r != 0 & cnt[r] != 0.
  - cnt[r] <= cnt[r] + inc - dec.
  - inc and dec in the same cycle leave the counter unchanged.
  - Writeback to a register with count 0 still writes data; the counter stays 0 (no underflow).
- issue_ready_o = !(cnt[issue_rd_i] == 2^CNT_W-1 & !dec for that register) | issue_rd_i == 0.
  - Combinational; independent of issue_valid_i.
  - A saturated counter never wraps.
- flush_i (synchronous): all counters <= 0 on that edge; an issue in the same cycle is discarded.
  - A writeback in the same cycle still updates register data.
  - Later writebacks of flushed instructions write data but do not decrement.
- Multiple read ports may address the same register; all return identical data.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read whose address equals wb_rd_i (non-zero) while wb_valid_i is high returns wb_data_i in the same cycle.
  - rd_busy_o for that port is computed using the post-decrement count, so a last pending write releases the stall in its writeback cycle.
- Undefined:
  - Reads return the stored value; the new value is visible the cycle after the write.
  - rd_busy_o uses the pre-update count, so release comes one cycle later.

Test Plan:
- Reset with rd_addr_i = {5'd3, 5'd0} -> rd_data_o = 0, rd_busy_o = 0, issue_ready_o = 1. Write x3 = 0xDEADBEEF -> next cycle port1 reads 0xDEADBEEF; a write to x0 -> x0 still reads 0.
- Issue rd = 5, then read x5 -> rd_busy_o = 1, hazard_o = 1.
  - Writeback x5 = 0x1234: with REGFILE_BYPASS_EN, busy = 0 and data = 0x1234 the same cycle.
  - Without REGFILE_BYPASS_EN, both change the next cycle.
- CNT_W = 2: issue rd = 7 three times -> issue_ready_o = 0 for rd = 7. Issue plus writeback to x7 in the same cycle -> ready = 1 and count stays 3. Three writebacks -> busy clears.
- Issue rd = 9 twice, then flush_i -> busy = 0 next cycle. A later writeback x9 = 0xAA -> data = 0xAA, count stays 0.
- NUM_READ = 3, REG_COUNT = 16, XLEN = 64: all ports read x15 after writing 0xFFFF_0000_FFFF_0000 -> all three ports identical.
- Assert rst_n low mid-stream with counters non-zero -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Parametrised register file with a per-register pending-write
//            scoreboard. REGFILE_BYPASS_EN forwards writeback data to reads.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int  XLEN      = 32,
    parameter int  REG_COUNT = 32,
    parameter int  NUM_READ  = 2,
    parameter int  CNT_W     = 2,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_READ*AW-1:0]   rd_addr_i,
    output logic [NUM_READ*XLEN-1:0] rd_data_o,
    output logic [NUM_READ-1:0]      rd_busy_o,
    input  logic                     issue_valid_i,
    input  logic [AW-1:0]            issue_rd_i,
    output logic                     issue_ready_o,
    input  logic                     wb_valid_i,
    input  logic [AW-1:0]            wb_rd_i,
    input  logic [XLEN-1:0]          wb_data_i,
    input  logic                     flush_i,
    output logic                     hazard_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]  regs_q [REG_COUNT];
    logic [XLEN-1:0]  regs_d [REG_COUNT];
    logic [CNT_W-1:0] cnt_q  [REG_COUNT];
    logic [CNT_W-1:0] cnt_d  [REG_COUNT];

    logic wb_en;
    logic wb_dec;
    logic issue_fire;

    assign wb_en  = wb_valid_i && (wb_rd_i != '0);
    assign wb_dec = wb_en && (cnt_q[wb_rd_i] != '0);

    // A saturated destination is still accepted when its retiring write lands this cycle.
    assign issue_ready_o = (issue_rd_i == '0)
                        || (cnt_q[issue_rd_i] != CNT_MAX)
                        || (wb_dec && (wb_rd_i == issue_rd_i));

    assign issue_fire = issue_valid_i && issue_ready_o && (issue_rd_i != '0) && !flush_i;

    always_comb begin
        for (int r = 0; r < REG_COUNT; r++) begin
            regs_d[r] = regs_q[r];
            cnt_d[r]  = cnt_q[r];
            if (wb_en && (wb_rd_i == AW'(r))) begin
                regs_d[r] = wb_data_i;
            end
            if (flush_i) begin
                cnt_d[r] = '0;
            end else begin
                cnt_d[r] = cnt_q[r]
                         + CNT_W'(issue_fire && (issue_rd_i == AW'(r)))
                         - CNT_W'(wb_dec && (wb_rd_i == AW'(r)));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < REG_COUNT; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd_port
        logic [AW-1:0] addr;
        assign addr = rd_addr_i[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        logic wb_hit;
        assign wb_hit = wb_en && (wb_rd_i == addr);
        assign rd_data_o[k*XLEN +: XLEN] = wb_hit ? wb_data_i : regs_q[addr];
        // Busy reflects the count after this cycle's retiring write.
        assign rd_busy_o[k] = (cnt_q[addr] != '0)
                           && !(wb_hit && (cnt_q[addr] == CNT_W'(1)));
`else
        assign rd_data_o[k*XLEN +: XLEN] = regs_q[addr];
        assign rd_busy_o[k] = (cnt_q[addr] != '0);
`endif
    end

    assign hazard_o = |rd_busy_o;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Scoreboard bench for regfile_scoreboard (default and wide builds).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [63:0] WIDE_V = 64'hFFFF_0000_FFFF_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        hazard;

    logic [11:0]  w_addr;
    logic [191:0] w_data;
    logic [2:0]   w_busy;
    logic         w_issue_valid;
    logic [3:0]   w_issue_rd;
    logic         w_ready;
    logic         w_wb_valid;
    logic [3:0]   w_wb_rd;
    logic [63:0]  w_wb_data;
    logic         w_flush;
    logic         w_haz;

    regfile_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_ready_o(issue_ready),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .flush_i(flush), .hazard_o(hazard)
    );

    regfile_scoreboard #(.XLEN(64), .REG_COUNT(16), .NUM_READ(3), .CNT_W(2)) dut_wide (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_i(w_addr), .rd_data_o(w_data), .rd_busy_o(w_busy),
        .issue_valid_i(w_issue_valid), .issue_rd_i(w_issue_rd), .issue_ready_o(w_ready),
        .wb_valid_i(w_wb_valid), .wb_rd_i(w_wb_rd), .wb_data_i(w_wb_data),
        .flush_i(w_flush), .hazard_o(w_haz)
    );

    typedef struct {
        int          cyc;
        bit          sel;
        string       name;
        logic [63:0] d0, d1, d2;
        logic [2:0]  busy;
        logic        rdy, haz;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void exp_main(string n, logic [31:0] d0, logic [31:0] d1,
                                     logic [1:0] b, logic r, logic h);
        exp_t e;
        e.cyc = cyc; e.sel = 1'b0; e.name = n;
        e.d0 = {32'h0, d0}; e.d1 = {32'h0, d1}; e.d2 = '0;
        e.busy = {1'b0, b}; e.rdy = r; e.haz = h;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_wide(string n, logic [63:0] d, logic [2:0] b,
                                     logic r, logic h);
        exp_t e;
        e.cyc = cyc; e.sel = 1'b1; e.name = n;
        e.d0 = d; e.d1 = d; e.d2 = d;
        e.busy = b; e.rdy = r; e.haz = h;
        exp_q.push_back(e);
    endfunction

    // Monitor: compare every expectation due by this cycle, mid-cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            n_chk++;
            if (!mon_e.sel) begin
                if ({rd_data, rd_busy, issue_ready, hazard} !==
                    {mon_e.d1[31:0], mon_e.d0[31:0], mon_e.busy[1:0], mon_e.rdy, mon_e.haz}) begin
                    n_fail++;
                    $display("FAIL %s: got data=%h busy=%b ready=%b hazard=%b, expected data=%h busy=%b ready=%b hazard=%b",
                             mon_e.name, rd_data, rd_busy, issue_ready, hazard,
                             {mon_e.d1[31:0], mon_e.d0[31:0]}, mon_e.busy[1:0], mon_e.rdy, mon_e.haz);
                end
            end else begin
                if ({w_data, w_busy, w_ready, w_haz} !==
                    {mon_e.d2, mon_e.d1, mon_e.d0, mon_e.busy, mon_e.rdy, mon_e.haz}) begin
                    n_fail++;
                    $display("FAIL %s: got data=%h busy=%b ready=%b hazard=%b, expected data=%h busy=%b ready=%b hazard=%b",
                             mon_e.name, w_data, w_busy, w_ready, w_haz,
                             {mon_e.d2, mon_e.d1, mon_e.d0}, mon_e.busy, mon_e.rdy, mon_e.haz);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr = {5'd3, 5'd0};
        issue_valid = 1'b0; issue_rd = 5'd0;
        wb_valid = 1'b0; wb_rd = 5'd0; wb_data = '0;
        flush = 1'b0;
        w_addr = {4'd15, 4'd15, 4'd15};
        w_issue_valid = 1'b0; w_issue_rd = 4'd0;
        w_wb_valid = 1'b0; w_wb_rd = 4'd0; w_wb_data = '0;
        w_flush = 1'b0;

        step(); exp_main("reset", 0, 0, 2'b00, 1, 0);
                exp_wide("wide_reset", 64'h0, 3'b000, 1, 0);

        step(); rst_n = 1'b1; wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
                exp_main("wr_x3_same", 0, BYP ? 32'hDEADBEEF : 32'h0, 2'b00, 1, 0);
        step(); wb_rd = 5'd0; wb_data = 32'h5555_5555;
                exp_main("x3_read", 0, 32'hDEADBEEF, 2'b00, 1, 0);
        step(); wb_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd5; rd_addr = {5'd5, 5'd0};
                exp_main("x0_ignored", 0, 0, 2'b00, 1, 0);
        step(); issue_valid = 1'b0;
                exp_main("x5_busy", 0, 0, 2'b10, 1, 1);
        step(); wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
                exp_main("wb_x5", 0, BYP ? 32'h1234 : 32'h0, BYP ? 2'b00 : 2'b10, 1, BYP ? 1'b0 : 1'b1);
        step(); wb_valid = 1'b0;
                exp_main("x5_after", 0, 32'h1234, 2'b00, 1, 0);

        step(); issue_valid = 1'b1; issue_rd = 5'd7; rd_addr = {5'd7, 5'd7};
                w_wb_valid = 1'b1; w_wb_rd = 4'd15; w_wb_data = WIDE_V;
                exp_main("iss7_a", 0, 0, 2'b00, 1, 0);
                exp_wide("wide_wr", BYP ? WIDE_V : 64'h0, 3'b000, 1, 0);
        step(); w_wb_valid = 1'b0;
                exp_main("iss7_b", 0, 0, 2'b11, 1, 1);
                exp_wide("wide_rd", WIDE_V, 3'b000, 1, 0);
        step(); exp_main("iss7_c", 0, 0, 2'b11, 1, 1);
        step(); exp_main("sat_ready0", 0, 0, 2'b11, 0, 1);
        step(); wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
                exp_main("iss_wb_same", BYP ? 32'h77 : 0, BYP ? 32'h77 : 0, 2'b11, 1, 1);
        step(); issue_valid = 1'b0; wb_valid = 1'b0;
                exp_main("cnt_stays3", 32'h77, 32'h77, 2'b11, 0, 1);
        step(); wb_valid = 1'b1; wb_data = 32'h71;
                exp_main("wb7_1", BYP ? 32'h71 : 32'h77, BYP ? 32'h71 : 32'h77, 2'b11, 1, 1);
        step(); wb_data = 32'h72;
                exp_main("wb7_2", BYP ? 32'h72 : 32'h71, BYP ? 32'h72 : 32'h71, 2'b11, 1, 1);
        step(); wb_data = 32'h73;
                exp_main("wb7_3", BYP ? 32'h73 : 32'h72, BYP ? 32'h73 : 32'h72,
                         BYP ? 2'b00 : 2'b11, 1, BYP ? 1'b0 : 1'b1);
        step(); wb_valid = 1'b0;
                exp_main("x7_clear", 32'h73, 32'h73, 2'b00, 1, 0);

        step(); issue_valid = 1'b1; issue_rd = 5'd9; rd_addr = {5'd9, 5'd9};
                exp_main("iss9_a", 0, 0, 2'b00, 1, 0);
        step(); exp_main("iss9_b", 0, 0, 2'b11, 1, 1);
        step(); flush = 1'b1;
                exp_main("flush_cyc", 0, 0, 2'b11, 1, 1);
        step(); flush = 1'b0; issue_valid = 1'b0;
                exp_main("flush_clear", 0, 0, 2'b00, 1, 0);
        step(); wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'hAA;
                exp_main("wb9_flushed", BYP ? 32'hAA : 0, BYP ? 32'hAA : 0, 2'b00, 1, 0);
        step(); wb_valid = 1'b0; issue_valid = 1'b1;
                exp_main("no_underflow", 32'hAA, 32'hAA, 2'b00, 1, 0);
        step(); issue_valid = 1'b0;
                exp_main("iss9_after", 32'hAA, 32'hAA, 2'b11, 1, 1);

        step(); rst_n = 1'b0; rd_addr = {5'd3, 5'd9};
                exp_main("async_rst", 0, 0, 2'b00, 1, 0);
                exp_wide("wide_async_rst", 64'h0, 3'b000, 1, 0);

        step();
        step();
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL %s: got no sample, expected a check at cycle %0d", mon_e.name, mon_e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
